// File: rtl/dm_bus.sv
// dm_bus: wait-stated byte/half/word data memory with a req/ready handshake.
// Ports: clk, rst (async, active-high); req/we/addr/size/sext/din describe one access,
// sampled only in IDLE; dout is the extended load result, ready a one-cycle completion
// pulse, busy spans acceptance through the ready cycle, align_err flags misalignment.
// Define DM_ALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module dm_bus #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              ready,
  output logic              busy,
  output logic              align_err
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WC = 4'(WAIT_CYC);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic l_we, l_sext;
  logic [ADDR_W-1:0] l_addr;
  logic [1:0] l_size;
  logic [31:0] l_din;
  logic o_we, o_sext, commit, mis;
  logic [ADDR_W-1:0] o_addr;
  logic [1:0] o_size;
  logic [31:0] o_din, rd, wd, ld;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic [3:0] be;
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    commit = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nx = (WC == 4'd0) ? DONE : WAIT;
        cnt_nx = WC;
        commit = (WC == 4'd0);
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = DONE;
          commit = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // With zero wait states the commit edge is the acceptance edge, so use live inputs then.
  assign o_we   = (state == IDLE) ? we   : l_we;
  assign o_addr = (state == IDLE) ? addr : l_addr;
  assign o_size = (state == IDLE) ? size : l_size;
  assign o_sext = (state == IDLE) ? sext : l_sext;
  assign o_din  = (state == IDLE) ? din  : l_din;
`ifdef DM_ALIGN_CHECK_EN
  assign mis = (o_size == 2'b01 && o_addr[0]) || (o_size[1] && o_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign rd   = mem[o_addr[ADDR_W-1:2]];
  assign bsel = rd[{o_addr[1:0], 3'b000} +: 8];
  assign hsel = rd[{o_addr[1], 4'b0000} +: 16];
  assign ld   = (o_size == 2'b00) ? {{24{o_sext & bsel[7]}}, bsel} :
                (o_size == 2'b01) ? {{16{o_sext & hsel[15]}}, hsel} : rd;
  assign be   = (o_size == 2'b00) ? 4'b0001 << o_addr[1:0] :
                (o_size == 2'b01) ? (o_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd   = (o_size == 2'b00) ? {4{o_din[7:0]}} :
                (o_size == 2'b01) ? {2{o_din[15:0]}} : o_din;
  assign busy  = (state != IDLE);
  assign ready = (state == DONE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      dout <= 32'h0;
      align_err <= 1'b0;
      l_we <= 1'b0;
      l_addr <= '0;
      l_size <= 2'b00;
      l_sext <= 1'b0;
      l_din <= 32'h0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      align_err <= commit && mis;
      if (commit && !o_we) dout <= mis ? 32'h0 : ld;
      if (state == IDLE && req) begin
        l_we <= we;
        l_addr <= addr;
        l_size <= size;
        l_sext <= sext;
        l_din <= din;
      end
    end
  end
  // Memory is not reset; a reset before the commit edge leaves it untouched.
  always_ff @(posedge clk) begin
    if (commit && o_we && !mis)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[o_addr[ADDR_W-1:2]][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_dm_bus.sv
// tb_dm_bus: scoreboard bench for dm_bus (WAIT_CYC=2 main instance, WAIT_CYC=0 second instance).
module tb_dm_bus;
  logic clk = 0, rst = 1;
  logic req = 0, we = 0, sext = 0;
  logic [11:0] addr = 0;
  logic [1:0] size = 0;
  logic [31:0] din = 0, dout;
  logic ready, busy, align_err;
  logic req1 = 0, we1 = 0;
  logic [11:0] addr1 = 0;
  logic [1:0] size1 = 2'b10;
  logic [31:0] din1 = 0, dout1;
  logic ready1, busy1, al1;
  int checks = 0, errors = 0, cyc = 0, busy_run = 0;
  logic [31:0] last = 0;
  typedef struct { logic [31:0] d; logic a; int t; } exp_t;
  exp_t sb[$];
  logic [31:0] v[4] = '{32'h11110001, 32'h22220002, 32'h33330003, 32'h44440004};
`ifdef DM_ALIGN_CHECK_EN
  localparam logic AC = 1'b1;
`else
  localparam logic AC = 1'b0;
`endif

  dm_bus #(.ADDR_W(12), .WAIT_CYC(2)) u0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size), .sext(sext),
    .din(din), .dout(dout), .ready(ready), .busy(busy), .align_err(align_err));
  dm_bus #(.ADDR_W(12), .WAIT_CYC(0)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .size(size1), .sext(1'b0),
    .din(din1), .dout(dout1), .ready(ready1), .busy(busy1), .align_err(al1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // Monitor: every ready pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    busy_run = busy ? busy_run + 1 : 0;
    if (ready) begin
      if (sb.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("dout", dout, e.d);
        chk("align_err", {31'd0, align_err}, {31'd0, e.a});
        chk("latency", 32'(cyc - e.t), 32'd3);
        chk("busy_cycles", 32'(busy_run), 32'd3);
      end
    end
  end

  // Issue one access; inputs are scrambled after acceptance so only latched copies matter.
  task automatic op(input logic w, input logic [11:0] a, input logic [1:0] s, input logic x,
                    input logic [31:0] d, input logic [31:0] ed, input logic ea);
    int n = 0;
    sb.push_back('{ed, ea, cyc});
    req = 1; we = w; addr = a; size = s; sext = x; din = d;
    @(negedge clk);
    req = 1; we = ~w; addr = ~a; size = ~s; sext = ~x; din = 32'hDEADBEEF;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    if (!ready) chk("timeout", 32'd0, 32'd1);
    req = 0;
    @(negedge clk);
    if (!w) last = ed;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_align", {31'd0, align_err}, 32'd0);
    rst = 0;
    op(1, 12'h013, 2'b00, 0, 32'h12345680, last, 0);
    op(0, 12'h013, 2'b00, 1, 0, 32'hFFFFFF80, 0);
    op(0, 12'h013, 2'b00, 0, 0, 32'h00000080, 0);
    op(0, 12'h010, 2'b10, 0, 0, 32'h80000000, 0);
    op(1, 12'h010, 2'b10, 0, 32'h12345678, last, 0);
    op(0, 12'h010, 2'b10, 0, 0, 32'h12345678, 0);
    op(1, 12'h022, 2'b01, 0, 32'h5555BEEF, last, 0);
    op(0, 12'h022, 2'b01, 1, 0, 32'hFFFFBEEF, 0);
    op(0, 12'h020, 2'b10, 0, 0, 32'hBEEF0000, 0);
    // Reset while a store sits in WAIT.
    req = 1; we = 1; addr = 12'h030; size = 2'b10; din = 32'hAAAAAAAA;
    @(negedge clk);
    req = 0;
    rst = 1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_dout", dout, 32'h0);
    @(negedge clk);
    rst = 0;
    last = 0;
    op(0, 12'h030, 2'b10, 0, 0, 32'h00000000, 0);
    op(1, 12'h041, 2'b10, 0, 32'h11111111, last, AC);
    op(0, 12'h040, 2'b10, 0, 0, AC ? 32'h0 : 32'h11111111, 0);
    op(0, 12'h023, 2'b01, 0, 0, AC ? 32'h0 : 32'h0000BEEF, AC);
    // Zero wait states: req held four cycles, only every second edge accepts.
    req1 = 1; we1 = 1; addr1 = 12'h000; din1 = v[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w0_ready", {31'd0, ready1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("w0_busy", {31'd0, busy1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i < 3) din1 = v[i+1];
    end
    we1 = 0;
    @(negedge clk);
    req1 = 0;
    chk("w0_ready_load", {31'd0, ready1}, 32'd1);
    chk("w0_dout", dout1, 32'h33330003);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
